// File: rtl/eth_pfc_pkg.sv
// -----------------------------------------------------------------------------
// eth_pfc_pkg
//
// Purpose: shared constants and helpers for the receive-side pause controller.
//          Holds the 802.3x / 802.1Qbb opcodes and the pause quantum size.
//          It also fixes the timer layout: priority timers 0..7 and the
//          link-level timer at index 8. Last, it provides the saturating
//          increment used by the pause-frame statistics.
//
// Ports:   none (package).
// -----------------------------------------------------------------------------
package eth_pfc_pkg;

    // MAC control opcodes of the frames the upstream decoder hands us.
    localparam logic [15:0] PAUSE_OPCODE_LFC   = 16'h0001;
    localparam logic [15:0] PAUSE_OPCODE_PFC   = 16'h0101;

    // One pause quantum is 512 bit times.
    localparam int          PAUSE_QUANTUM_BITS = 512;

    // Timer layout: one timer per PFC priority plus one link-level timer.
    localparam int          PFC_CLASSES        = 8;
    localparam int          PAUSE_IDX_LFC      = 8;
    localparam int          PAUSE_TIMERS       = PFC_CLASSES + 1;

    // Width of one pause_time field in the frame.
    localparam int          PAUSE_QUANTA_W     = 16;
    typedef logic [PAUSE_QUANTA_W-1:0] pause_quanta_t;

    // Statistics counters are 16 bits and stick at all-ones.
    localparam int          STAT_W             = 16;
    localparam logic [STAT_W-1:0] STAT_MAX     = '1;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == STAT_MAX) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/eth_pfc_pause_ctrl_timer.sv
// -----------------------------------------------------------------------------
// eth_pause_timer
//
// Purpose: one pause countdown timer. It has a quanta count and a sub-counter
//          that divides clk down to one pause quantum. The timer runs while
//          quanta is non-zero. A load always wins over the countdown in the
//          same cycle, and a load of zero stops the timer at once.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   load        in   load load_value this cycle (overrides any countdown)
//   load_value  in   new quanta value (0 = stop)
//   run_next    out  timer-running state after the coming edge
//                    (quanta_next != 0); the parent registers it
// -----------------------------------------------------------------------------
module eth_pause_timer
    import eth_pfc_pkg::*;
#(
    parameter int CYCLES_PER_QUANTUM = 8,   // must be >= 1
    parameter int QUANTA_WIDTH       = PAUSE_QUANTA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [QUANTA_WIDTH-1:0] load_value,
    output logic                    run_next
);

    // A single-cycle quantum still needs a 1-bit sub-counter, which then stays at 0.
    localparam int SUB_W = (CYCLES_PER_QUANTUM > 1) ? $clog2(CYCLES_PER_QUANTUM) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CYCLES_PER_QUANTUM - 1);

    logic [QUANTA_WIDTH-1:0] quanta_q, quanta_d;
    logic [SUB_W-1:0]        sub_q,    sub_d;

    // Loading sets sub to the top of a full quantum. The countdown then lasts
    // exactly load_value * CYCLES_PER_QUANTUM edges until quanta reaches 0.
    always_comb begin
        quanta_d = quanta_q;
        sub_d    = sub_q;
        if (load) begin
            quanta_d = load_value;
            sub_d    = SUB_MAX;
        end else if (quanta_q != '0) begin
            if (sub_q == '0) begin
                sub_d    = SUB_MAX;
                quanta_d = quanta_q - QUANTA_WIDTH'(1);
            end else begin
                sub_d    = sub_q - SUB_W'(1);
            end
        end
    end

    assign run_next = (quanta_d != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quanta_q <= '0;
            sub_q    <= '0;
        end else begin
            quanta_q <= quanta_d;
            sub_q    <= sub_d;
        end
    end

endmodule

// File: rtl/eth_pfc_pause_ctrl.sv
// -----------------------------------------------------------------------------
// eth_pfc_pause_ctrl
//
// Purpose: receive-side pause controller. It turns decoded LFC (802.3x) and
//          PFC (802.1Qbb) pause frames into the 9-bit pause_req vector for the
//          TX FIFO stage. Bits [7:0] are the priorities and bit [8] is the link.
//          Each bit is driven by its own quanta countdown timer.
//
// Handshake: rx_pause_valid is a one-cycle strobe with no back-pressure (no
//          ready). A frame is taken in the cycle the strobe is high, and only
//          if its frame type is enabled by cfg_lfc_en / cfg_pfc_en. Frames that
//          are not taken leave no trace.
//          pause_req / pause_ack is a level handshake, not a transfer. The
//          timers never wait for pause_ack. pause_active reports where both
//          are high, and an ack with no matching request is ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_pause_valid      decoded pause frame strobe
//   rx_pause_lfc        1 = LFC frame, 0 = PFC frame
//   rx_pause_enable     PFC class-enable vector (ignored for LFC)
//   rx_pause_quanta     class i time at [i*QUANTA_WIDTH +: QUANTA_WIDTH]; LFC uses field 0
//   cfg_lfc_en          accept LFC frames
//   cfg_pfc_en          accept PFC frames
//   cfg_force_pause     software pause, ORed into pause_req
//   pause_req           registered timer-running | cfg_force_pause
//   pause_ack           acknowledge from the TX FIFO stage
//   pause_active        registered pause_req & pause_ack
//   stat_xoff_count     saturating count of accepted frames loading a non-zero time
//   stat_xon_count      saturating count of accepted frames loading only zeros
//   busy                registered OR of the timer-running bits (force excluded)
// -----------------------------------------------------------------------------
module eth_pfc_pause_ctrl
    import eth_pfc_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int CYCLES_PER_QUANTUM = PAUSE_QUANTUM_BITS / DATA_WIDTH,  // must be >= 1
    parameter int QUANTA_WIDTH       = PAUSE_QUANTA_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx_pause_valid,
    input  logic                                rx_pause_lfc,
    input  logic [PFC_CLASSES-1:0]              rx_pause_enable,
    input  logic [PFC_CLASSES*QUANTA_WIDTH-1:0] rx_pause_quanta,
    input  logic                                cfg_lfc_en,
    input  logic                                cfg_pfc_en,
    input  logic [PAUSE_TIMERS-1:0]             cfg_force_pause,
    output logic [PAUSE_TIMERS-1:0]             pause_req,
    input  logic [PAUSE_TIMERS-1:0]             pause_ack,
    output logic [PAUSE_TIMERS-1:0]             pause_active,
    output logic [STAT_W-1:0]                   stat_xoff_count,
    output logic [STAT_W-1:0]                   stat_xon_count,
    output logic                                busy
);

    logic                    accept;
    logic                    frame_xoff;
    logic [PAUSE_TIMERS-1:0] load_en;
    logic [QUANTA_WIDTH-1:0] load_val [PAUSE_TIMERS];
    logic [PAUSE_TIMERS-1:0] run_next;

    // Only frame types switched on in the configuration are acted on.
    assign accept = rx_pause_valid &
                    ((rx_pause_lfc & cfg_lfc_en) | (~rx_pause_lfc & cfg_pfc_en));

    // Per-timer load decode. The link timer takes field 0, which is where the
    // single pause_time of an LFC frame sits.
    // frame_xoff is set when any timer that is really being loaded gets a
    // non-zero time. A PFC frame with an all-zero enable vector loads nothing,
    // so it counts as XON.
    always_comb begin
        load_en    = '0;
        frame_xoff = 1'b0;
        for (int i = 0; i < PFC_CLASSES; i++) begin
            load_val[i] = rx_pause_quanta[i*QUANTA_WIDTH +: QUANTA_WIDTH];
        end
        load_val[PAUSE_IDX_LFC] = rx_pause_quanta[0 +: QUANTA_WIDTH];

        if (accept) begin
            if (rx_pause_lfc) begin
                load_en[PAUSE_IDX_LFC] = 1'b1;
            end else begin
                load_en[PFC_CLASSES-1:0] = rx_pause_enable;
            end
        end

        for (int i = 0; i < PAUSE_TIMERS; i++) begin
            if (load_en[i] && (load_val[i] != '0)) begin
                frame_xoff = 1'b1;
            end
        end
    end

    for (genvar t = 0; t < PAUSE_TIMERS; t++) begin : g_timer
        eth_pause_timer #(
            .CYCLES_PER_QUANTUM (CYCLES_PER_QUANTUM),
            .QUANTA_WIDTH       (QUANTA_WIDTH)
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .load       (load_en[t]),
            .load_value (load_val[t]),
            .run_next   (run_next[t])
        );
    end

    // Output registers. pause_req follows the post-edge timer state, so a
    // frame strobed at edge N shows up on pause_req right after edge N.
    // pause_active pairs the registered request with the ack of this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_req       <= '0;
            pause_active    <= '0;
            busy            <= 1'b0;
            stat_xoff_count <= '0;
            stat_xon_count  <= '0;
        end else begin
            pause_req    <= run_next | cfg_force_pause;
            pause_active <= pause_req & pause_ack;
            busy         <= |run_next;
            if (accept) begin
                if (frame_xoff) begin
                    stat_xoff_count <= sat_inc(stat_xoff_count);
                end else begin
                    stat_xon_count  <= sat_inc(stat_xon_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_pfc_pause_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_pfc_pause_ctrl
//
// Bench for eth_pfc_pause_ctrl with CYCLES_PER_QUANTUM = 8.
// The reference model does not copy the timer's counters. Each loaded timer
// gets an absolute deadline, deadline = load_cycle + T * CPQ, and a timer is
// running while the cycle count is below its deadline. A compare process
// checks every DUT output against the model on every falling edge.
// Directed cases check hand-computed durations and counts through a small
// expected queue.
// -----------------------------------------------------------------------------
module tb_eth_pfc_pause_ctrl;

    localparam int CPQ = 8;
    localparam int QW  = 16;
    localparam int NT  = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    initial forever #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            rx_pause_valid  = 1'b0;
    logic            rx_pause_lfc    = 1'b0;
    logic [7:0]      rx_pause_enable = '0;
    logic [8*QW-1:0] rx_pause_quanta = '0;
    logic            cfg_lfc_en      = 1'b1;
    logic            cfg_pfc_en      = 1'b1;
    logic [NT-1:0]   cfg_force_pause = '0;
    logic [NT-1:0]   pause_req;
    logic [NT-1:0]   pause_ack       = '0;
    logic [NT-1:0]   pause_active;
    logic [15:0]     stat_xoff_count;
    logic [15:0]     stat_xon_count;
    logic            busy;

    eth_pfc_pause_ctrl #(
        .DATA_WIDTH         (64),
        .CYCLES_PER_QUANTUM (CPQ),
        .QUANTA_WIDTH       (QW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_pause_valid  (rx_pause_valid),
        .rx_pause_lfc    (rx_pause_lfc),
        .rx_pause_enable (rx_pause_enable),
        .rx_pause_quanta (rx_pause_quanta),
        .cfg_lfc_en      (cfg_lfc_en),
        .cfg_pfc_en      (cfg_pfc_en),
        .cfg_force_pause (cfg_force_pause),
        .pause_req       (pause_req),
        .pause_ack       (pause_ack),
        .pause_active    (pause_active),
        .stat_xoff_count (stat_xoff_count),
        .stat_xon_count  (stat_xon_count),
        .busy            (busy)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    bit          chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare a measured value against the next hand-computed literal.
    task automatic expect_lit(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty, got 0x%0h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint        cyc = 0;
    longint        deadline [NT];
    logic [NT-1:0] m_req    = '0;
    logic [NT-1:0] m_active = '0;
    logic          m_busy   = 1'b0;
    int            m_xoff   = 0;
    int            m_xon    = 0;
    bit            m_nz;
    bit            m_hit;
    bit            m_run;
    int            m_t;

    initial for (int i = 0; i < NT; i++) deadline[i] = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) deadline[i] = 0;
            m_req    = '0;
            m_active = '0;
            m_busy   = 1'b0;
            m_xoff   = 0;
            m_xon    = 0;
        end else begin
            cyc      = cyc + 1;
            m_active = m_req & pause_ack;
            if (rx_pause_valid && (rx_pause_lfc ? cfg_lfc_en : cfg_pfc_en)) begin
                m_nz = 1'b0;
                for (int i = 0; i < NT; i++) begin
                    m_hit = rx_pause_lfc ? (i == 8) : ((i < 8) && rx_pause_enable[i % 8]);
                    m_t   = int'(rx_pause_quanta[((i == 8) ? 0 : i)*QW +: QW]);
                    if (m_hit) begin
                        deadline[i] = cyc + longint'(m_t) * CPQ;
                        if (m_t != 0) m_nz = 1'b1;
                    end
                end
                if (m_nz) m_xoff = (m_xoff < 65535) ? m_xoff + 1 : 65535;
                else      m_xon  = (m_xon  < 65535) ? m_xon  + 1 : 65535;
            end
            m_busy = 1'b0;
            for (int i = 0; i < NT; i++) begin
                m_run    = (cyc < deadline[i]);
                m_req[i] = m_run | cfg_force_pause[i];
                m_busy   = m_busy | m_run;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("pause_req",    32'(pause_req),       32'(m_req));
            check("pause_active", 32'(pause_active),    32'(m_active));
            check("busy",         32'(busy),            32'(m_busy));
            check("xoff_count",   32'(stat_xoff_count), 32'(m_xoff));
            check("xon_count",    32'(stat_xon_count),  32'(m_xon));
        end
    end

    // ---------------- pause_ack driver ----------------
    // mode 0: ack low, mode 1: echo pause_req two stages later, mode 2: random
    int            ack_mode = 0;
    logic [NT-1:0] d0 = '0, d1 = '0, d2 = '0;
    initial forever begin
        @(posedge clk);
        #1;
        d2 = d1;
        d1 = d0;
        d0 = pause_req;
        case (ack_mode)
            1:       pause_ack = d2;
            2:       pause_ack = NT'($urandom);
            default: pause_ack = '0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic lfc, input logic [7:0] en, input logic [8*QW-1:0] q);
        @(posedge clk);
        #1;
        rx_pause_valid  = 1'b1;
        rx_pause_lfc    = lfc;
        rx_pause_enable = en;
        rx_pause_quanta = q;
        @(posedge clk);
        #1;
        rx_pause_valid  = 1'b0;
    endtask

    task automatic drive_random();
        @(posedge clk);
        #1;
        rx_pause_valid  = ($urandom_range(0, 2) == 0);
        rx_pause_lfc    = ($urandom_range(0, 3) == 0);
        rx_pause_enable = 8'($urandom);
        for (int i = 0; i < 8; i++)
            rx_pause_quanta[i*QW +: QW] = ($urandom_range(0, 63) == 0) ? 16'hFFFF
                                                                      : 16'($urandom_range(0, 4));
        cfg_lfc_en      = ($urandom_range(0, 7) != 0);
        cfg_pfc_en      = ($urandom_range(0, 7) != 0);
        cfg_force_pause = ($urandom_range(0, 15) == 0) ? NT'($urandom) : '0;
    endtask

    int hi_req [NT];
    int hi_act [NT];
    int sum_low;

    // Count, over n falling edges, how often each pause_req / pause_active bit is high.
    task automatic window(input int n);
        for (int i = 0; i < NT; i++) begin
            hi_req[i] = 0;
            hi_act[i] = 0;
        end
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NT; i++) begin
                if (pause_req[i])    hi_req[i]++;
                if (pause_active[i]) hi_act[i]++;
            end
        end
    endtask

    logic [8*QW-1:0] qv;

    // ---------------- main sequence ----------------
    initial begin
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_pause_req",    32'(pause_req),       32'd0);
        check("rst_pause_active", 32'(pause_active),    32'd0);
        check("rst_busy",         32'(busy),            32'd0);
        check("rst_xoff",         32'(stat_xoff_count), 32'd0);
        check("rst_xon",          32'(stat_xon_count),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: LFC, 3 quanta -> 24 cycles on bit 8 only
        qv = '0;
        qv[0*QW +: QW] = 16'd3;
        strobe(1'b1, 8'h00, qv);
        exp_q.push_back(32'd24);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        window(40);
        sum_low = 0;
        for (int i = 0; i < 8; i++) sum_low += hi_req[i];
        expect_lit("t1_req8_cycles", 32'(hi_req[8]));
        expect_lit("t1_req_low",     32'(sum_low));
        expect_lit("t1_xoff",        32'(stat_xoff_count));

        // 2: PFC, enable classes 0 and 2; class 1 carries a time but is disabled
        qv = '0;
        qv[0*QW +: QW] = 16'd2;
        qv[1*QW +: QW] = 16'd100;
        qv[2*QW +: QW] = 16'd1;
        strobe(1'b0, 8'b0000_0101, qv);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd0);
        window(40);
        expect_lit("t2_req0_cycles", 32'(hi_req[0]));
        expect_lit("t2_req2_cycles", 32'(hi_req[2]));
        expect_lit("t2_req1_cycles", 32'(hi_req[1]));

        // 3: class 3 XOFF, then XON 20 cycles later stops it on the next cycle
        qv = '0;
        qv[3*QW +: QW] = 16'd10;
        strobe(1'b0, 8'b0000_1000, qv);
        repeat (19) @(posedge clk);
        qv = '0;
        strobe(1'b0, 8'b0000_1000, qv);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        expect_lit("t3_req3_after_xon", 32'(pause_req[3]));
        expect_lit("t3_xon",            32'(stat_xon_count));

        // 4: reload exactly on the cycle timer 5 ticks -> full 4 quanta from the reload
        qv = '0;
        qv[5*QW +: QW] = 16'd2;
        strobe(1'b0, 8'b0010_0000, qv);
        repeat (6) @(posedge clk);
        qv[5*QW +: QW] = 16'd4;
        strobe(1'b0, 8'b0010_0000, qv);
        exp_q.push_back(32'd32);
        window(50);
        expect_lit("t4_req5_cycles", 32'(hi_req[5]));

        // 5: PFC disabled -> strobe ignored entirely
        cfg_pfc_en = 1'b0;
        qv = '1;
        strobe(1'b0, 8'hFF, qv);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd1);
        expect_lit("t5_req_ignored",  32'(pause_req));
        expect_lit("t5_xoff_ignored", 32'(stat_xoff_count));
        expect_lit("t5_xon_ignored",  32'(stat_xon_count));
        cfg_pfc_en = 1'b1;

        // random phase, model-checked every cycle
        ack_mode = 2;
        repeat (2500) drive_random();
        @(posedge clk);
        #1;
        rx_pause_valid  = 1'b0;
        cfg_force_pause = '0;
        cfg_lfc_en      = 1'b1;
        cfg_pfc_en      = 1'b1;
        ack_mode        = 0;

        // asynchronous reset in the middle of a count
        qv = '0;
        qv[0*QW +: QW] = 16'd50;
        strobe(1'b1, 8'h00, qv);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pause_req",    32'(pause_req),       32'd0);
        check("arst_pause_active", 32'(pause_active),    32'd0);
        check("arst_busy",         32'(busy),            32'd0);
        check("arst_xoff",         32'(stat_xoff_count), 32'd0);
        check("arst_xon",          32'(stat_xon_count),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 6a: ack echoes the request -> pause_active overlaps the request for 22 cycles
        ack_mode = 1;
        qv = '0;
        qv[0*QW +: QW] = 16'd3;
        strobe(1'b1, 8'h00, qv);
        exp_q.push_back(32'd24);
        exp_q.push_back(32'd22);
        window(40);
        expect_lit("t6_req8_cycles", 32'(hi_req[8]));
        expect_lit("t6_act8_cycles", 32'(hi_act[8]));
        ack_mode = 0;

        // 6b: 65536 back-to-back XOFF frames saturate the counter
        @(posedge clk);
        #1;
        rx_pause_valid  = 1'b1;
        rx_pause_lfc    = 1'b1;
        rx_pause_quanta = '0;
        rx_pause_quanta[0 +: QW] = 16'd1;
        repeat (65536) @(posedge clk);
        #1;
        rx_pause_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_FFFF);
        expect_lit("t6_xoff_saturated", 32'(stat_xoff_count));

        repeat (4) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
